// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types: reservation-station tags, data words, the broadcast record
// and the system-level producer count.
package cdb_arbiter_pkg;

   localparam int TAG_W = 4;

   typedef logic [TAG_W-1:0] rs_tag_t;
   typedef logic [31:0]      word32_t;

   typedef struct packed {
      rs_tag_t tag;
      word32_t val;
   } cdb_t;

   localparam rs_tag_t NO_VAL      = 4'd0;
   localparam int      CDB_NUM_REQ = 4;
   localparam cdb_t    CDB_IDLE    = '{tag: NO_VAL, val: 32'h0000_0000};

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-to-CDB bundle: per-producer result requests in, ready and broadcast out.
interface cdb_arbiter_if
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_REQ = CDB_NUM_REQ
);

   logic    [NUM_REQ-1:0] req_valid_i;
   rs_tag_t [NUM_REQ-1:0] req_tag_i;
   word32_t [NUM_REQ-1:0] req_val_i;
   logic    [NUM_REQ-1:0] req_spec_i;
   logic    [NUM_REQ-1:0] req_ready_o;
   logic                  kill_spec_i;
   cdb_t                  cdb_o;
   logic                  cdb_spec_o;

   modport master (
      output req_valid_i, req_tag_i, req_val_i, req_spec_i, kill_spec_i,
      input  req_ready_o, cdb_o, cdb_spec_o
   );

   modport slave (
      input  req_valid_i, req_tag_i, req_val_i, req_spec_i, kill_spec_i,
      output req_ready_o, cdb_o, cdb_spec_o
   );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant of the first request found
// at or after ptr, wrapping, via a double-width masked priority select.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic          grant_valid,
   output logic [PW-1:0] winner
);

   logic [2*N-1:0] dbl_s;
   logic [2*N-1:0] mask_s;
   logic [2*N-1:0] cand_s;

   // Upper copy of the request vector covers the wrap; lowest surviving bit wins.
   always_comb begin
      dbl_s = {req, req};
      for (int i = 0; i < 2 * N; i++) begin
         mask_s[i] = (i >= 32'(ptr)) ? 1'b1 : 1'b0;
      end
      cand_s      = dbl_s & mask_s;
      winner      = '0;
      grant_valid = 1'b0;
      for (int i = 2 * N - 1; i >= 0; i--) begin
         winner      = cand_s[i] ? PW'((i >= N) ? (i - N) : i) : winner;
         grant_valid = grant_valid | cand_s[i];
      end
   end

   // Decode the winning index into the one-hot grant.
   always_comb begin
      grant         = '0;
      grant[winner] = grant_valid;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: masks ineligible/killed results, grants one producer per cycle
// round-robin and registers the winner onto the common data bus.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter  int NUM_REQ = CDB_NUM_REQ,
   localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input logic          clk_i,
   input logic          reset_i,
   cdb_arbiter_if.slave bus
);

   logic [NUM_REQ-1:0] elig_s;
   logic [NUM_REQ-1:0] drop_s;
   logic [NUM_REQ-1:0] grant_s;
   logic [NUM_REQ-1:0] ready_s;
   logic               grant_valid_s;
   logic [PW-1:0]      winner_s;
   logic [PW-1:0]      ptr_r;
   cdb_t               cdb_r;
   logic               cdb_spec_r;

   // Killed speculative results are acknowledged and dropped rather than arbitrated.
   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) begin
         elig_s[k] = bus.req_valid_i[k] & (bus.req_tag_i[k] != NO_VAL)
                   & ~(bus.kill_spec_i & bus.req_spec_i[k]);
         drop_s[k] = bus.kill_spec_i & bus.req_valid_i[k] & bus.req_spec_i[k]
                   & (bus.req_tag_i[k] != NO_VAL);
      end
   end

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req         (elig_s),
      .ptr         (ptr_r),
      .grant       (grant_s),
      .grant_valid (grant_valid_s),
      .winner      (winner_s)
   );

   // Producers see nothing consumed while the arbiter is held in reset.
   always_comb begin
      if (reset_i) begin
         ready_s = '0;
      end else begin
         ready_s = grant_s | drop_s;
      end
   end

   // Bus register and round-robin pointer; the pointer only follows broadcast grants.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cdb_r      <= CDB_IDLE;
         cdb_spec_r <= 1'b0;
         ptr_r      <= '0;
      end else if (grant_valid_s) begin
         cdb_r      <= '{tag: bus.req_tag_i[winner_s], val: bus.req_val_i[winner_s]};
         cdb_spec_r <= bus.req_spec_i[winner_s];
         ptr_r      <= (winner_s == PW'(NUM_REQ - 1)) ? '0 : winner_s + PW'(1);
      end else begin
         cdb_r      <= CDB_IDLE;
         cdb_spec_r <= 1'b0;
         ptr_r      <= ptr_r;
      end
   end

   assign bus.req_ready_o = ready_s;
   assign bus.cdb_o       = cdb_r;
   assign bus.cdb_spec_o  = cdb_spec_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table followed by
// randomized traffic compared against a round-robin reference model.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int N = 4;

   logic clk_i;
   logic reset_i;
   int   checks;
   int   errors;

   cdb_arbiter_if #(.NUM_REQ(N)) bus ();

   cdb_arbiter #(.NUM_REQ(N)) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .bus     (bus)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   typedef struct {
      logic          rst;
      logic [N-1:0]  valid;
      logic [N-1:0]  spec;
      logic          kill;
      rs_tag_t [N-1:0] tags;
      logic [N-1:0]  exp_rdy;
      rs_tag_t       exp_tag;
      logic          exp_spec;
   } vec_t;

   vec_t tbl[$];

   // Reference model state: the bus contents expected after the next edge.
   int      m_ptr;
   rs_tag_t m_tag;
   word32_t m_val;
   logic    m_spec;
   logic [N-1:0] last_rdy;

   function automatic word32_t val_of(input int k, input rs_tag_t t);
      return (t == 4'd5) ? 32'hDEAD_BEEF : {24'hC0FFEE, 4'(k), t};
   endfunction

   function automatic vec_t mk(input logic rst, input logic [3:0] valid, input logic [3:0] spec,
                               input logic kill, input logic [15:0] tags, input logic [3:0] rdy,
                               input rs_tag_t tag, input logic sp);
      vec_t v;
      v.rst = rst; v.valid = valid; v.spec = spec; v.kill = kill; v.tags = tags;
      v.exp_rdy = rdy; v.exp_tag = tag; v.exp_spec = sp;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Spec-level rules: eligibility, search from ptr modulo N, kill acknowledgements.
   task automatic model_eval(output logic [N-1:0] rdy, output int win);
      logic [N-1:0] elig;
      win = -1;
      rdy = '0;
      for (int k = 0; k < N; k++) begin
         elig[k] = bus.req_valid_i[k] && (bus.req_tag_i[k] != NO_VAL)
                   && !(bus.kill_spec_i && bus.req_spec_i[k]);
         if (bus.kill_spec_i && bus.req_valid_i[k] && bus.req_spec_i[k] && bus.req_tag_i[k] != NO_VAL)
            rdy[k] = 1'b1;
      end
      for (int j = 0; j < N; j++) begin
         int k;
         k = (m_ptr + j) % N;
         if (win < 0 && elig[k]) win = k;
      end
      if (win >= 0) rdy[win] = 1'b1;
      if (reset_i) rdy = '0;
   endtask

   task automatic run_cycle(input string name, input bit use_tbl, input vec_t v);
      logic [N-1:0] rdy;
      int win;
      #2;
      model_eval(rdy, win);
      chk({name, " ready"}, 64'(bus.req_ready_o), 64'(rdy));
      if (use_tbl) chk({name, " tbl_ready"}, 64'(bus.req_ready_o), 64'(v.exp_rdy));
      last_rdy = bus.req_ready_o;
      if (reset_i) begin
         m_tag = NO_VAL; m_val = 32'h0; m_spec = 1'b0; m_ptr = 0;
      end else if (win >= 0) begin
         m_tag = bus.req_tag_i[win]; m_val = bus.req_val_i[win]; m_spec = bus.req_spec_i[win];
         m_ptr = (win + 1) % N;
      end else begin
         m_tag = NO_VAL; m_val = 32'h0; m_spec = 1'b0;
      end
      @(posedge clk_i);
      #1;
      chk({name, " cdb_tag"}, 64'(bus.cdb_o.tag), 64'(m_tag));
      chk({name, " cdb_val"}, 64'(bus.cdb_o.val), 64'(m_val));
      chk({name, " cdb_spec"}, 64'(bus.cdb_spec_o), 64'(m_spec));
      if (use_tbl) begin
         chk({name, " tbl_tag"}, 64'(bus.cdb_o.tag), 64'(v.exp_tag));
         chk({name, " tbl_spec"}, 64'(bus.cdb_spec_o), 64'(v.exp_spec));
      end
   endtask

   task automatic apply(input vec_t v);
      reset_i         = v.rst;
      bus.req_valid_i = v.valid;
      bus.req_spec_i  = v.spec;
      bus.kill_spec_i = v.kill;
      bus.req_tag_i   = v.tags;
      for (int k = 0; k < N; k++) bus.req_val_i[k] = val_of(k, v.tags[k]);
   endtask

   logic    p_valid [N];
   rs_tag_t p_tag   [N];
   logic    p_spec  [N];

   initial begin
      vec_t v;
      checks = 0; errors = 0;
      m_ptr = 0; m_tag = NO_VAL; m_val = 32'h0; m_spec = 1'b0; last_rdy = '0;
      // reset, single request, wrap from ptr=3, full rotation, kill, NO_VAL, reset after grant
      tbl.push_back(mk(1, 4'b1111, 4'b0000, 0, {4'd4, 4'd3, 4'd2, 4'd1}, 4'b0000, NO_VAL, 0));
      tbl.push_back(mk(1, 4'b1111, 4'b0000, 0, {4'd4, 4'd3, 4'd2, 4'd1}, 4'b0000, NO_VAL, 0));
      tbl.push_back(mk(0, 4'b0100, 4'b0000, 0, {4'd0, 4'd5, 4'd0, 4'd0}, 4'b0100, 4'd5, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 16'h0000, 4'b0000, NO_VAL, 0));
      tbl.push_back(mk(0, 4'b0011, 4'b0000, 0, {4'd0, 4'd0, 4'd2, 4'd1}, 4'b0001, 4'd1, 0));
      tbl.push_back(mk(0, 4'b0010, 4'b0000, 0, {4'd0, 4'd0, 4'd2, 4'd1}, 4'b0010, 4'd2, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 16'h0000, 4'b0000, NO_VAL, 0));
      tbl.push_back(mk(0, 4'b1000, 4'b0000, 0, {4'd7, 4'd0, 4'd0, 4'd0}, 4'b1000, 4'd7, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, {4'd11, 4'd10, 4'd9, 4'd8}, 4'b0001, 4'd8, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, {4'd11, 4'd10, 4'd9, 4'd8}, 4'b0010, 4'd9, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, {4'd11, 4'd10, 4'd9, 4'd8}, 4'b0100, 4'd10, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, {4'd11, 4'd10, 4'd9, 4'd8}, 4'b1000, 4'd11, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, {4'd11, 4'd10, 4'd9, 4'd8}, 4'b0001, 4'd8, 0));
      tbl.push_back(mk(0, 4'b0111, 4'b0101, 1, {4'd0, 4'd6, 4'd4, 4'd3}, 4'b0111, 4'd4, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 16'h0000, 4'b0000, NO_VAL, 0));
      tbl.push_back(mk(0, 4'b0001, 4'b0000, 0, 16'h0000, 4'b0000, NO_VAL, 0));
      tbl.push_back(mk(0, 4'b0001, 4'b0000, 0, 16'h0000, 4'b0000, NO_VAL, 0));
      tbl.push_back(mk(0, 4'b0001, 4'b0001, 0, {4'd0, 4'd0, 4'd0, 4'd12}, 4'b0001, 4'd12, 1));
      tbl.push_back(mk(0, 4'b0100, 4'b0000, 0, {4'd0, 4'd13, 4'd0, 4'd0}, 4'b0100, 4'd13, 0));
      tbl.push_back(mk(1, 4'b0100, 4'b0000, 0, {4'd0, 4'd13, 4'd0, 4'd0}, 4'b0000, NO_VAL, 0));
      tbl.push_back(mk(0, 4'b0100, 4'b0000, 0, {4'd0, 4'd13, 4'd0, 4'd0}, 4'b0100, 4'd13, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 16'h0000, 4'b0000, NO_VAL, 0));

      apply(tbl[0]);
      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i]);
         run_cycle($sformatf("vec%0d", i), 1'b1, tbl[i]);
      end

      // Randomized producers that hold each result until it is acknowledged.
      for (int k = 0; k < N; k++) begin
         p_valid[k] = 1'b0; p_tag[k] = NO_VAL; p_spec[k] = 1'b0;
      end
      v = tbl[0];
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < N; k++) begin
            if (last_rdy[k] || (p_valid[k] && p_tag[k] == NO_VAL && $urandom_range(0, 3) == 0))
               p_valid[k] = 1'b0;
            if (!p_valid[k] && $urandom_range(0, 1) == 1) begin
               p_valid[k] = 1'b1;
               p_tag[k]   = 4'($urandom_range(0, 15));
               p_spec[k]  = ($urandom_range(0, 2) == 0);
            end
            bus.req_valid_i[k] = p_valid[k];
            bus.req_tag_i[k]   = p_tag[k];
            bus.req_spec_i[k]  = p_spec[k];
            bus.req_val_i[k]   = val_of(k, p_tag[k]) ^ 32'(c << 8);
         end
         bus.kill_spec_i = ($urandom_range(0, 7) == 0);
         reset_i         = ($urandom_range(0, 49) == 0);
         run_cycle($sformatf("rnd%0d", c), 1'b0, v);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
